// File: rtl/sha_req_sched_pkg.sv
// Shared types and constants for the SHA request scheduler.
// FSM state encoding, block/digest widths, core latency, pointer wrap helper.
package sha_req_sched_pkg;

  localparam int SHA_BLK_W = 512;
  localparam int SHA_DIG_W = 256;
  localparam int CORE_LAT  = 67;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } state_t;

  function automatic int unsigned wrap_inc(
    input int unsigned i,
    input int unsigned n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/sha_req_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set req at or above ptr, wrapping.
// Ports: req (NUM_REQ), ptr (ID_W) -> gnt one-hot, gnt_idx, any.
module sha_req_sched_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  int w_j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_j = int'(ptr) + i;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!any && req[w_j]) begin
        any      = 1'b1;
        gnt[w_j] = 1'b1;
        gnt_idx  = ID_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/sha_req_sched.sv
// Shares one sha_core among NUM_REQ requesters, one block per grant.
// Ports: req_* (bus side), rsp_* (digest out), core_* (to/from sha_core), busy.
module sha_req_sched
  import sha_req_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 80
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*SHA_BLK_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [SHA_DIG_W-1:0]         rsp_hash,
  output logic [ID_W-1:0]              rsp_id,
  output logic                         rsp_err,
  output logic                         core_clr,
  output logic [SHA_BLK_W-1:0]         core_msg,
  input  logic                         core_valid,
  input  logic [SHA_DIG_W-1:0]         core_hash,
  output logic                         busy
);

  // Never let the abort fire before the core can possibly finish.
  localparam int TO = (TIMEOUT > CORE_LAT) ? TIMEOUT : CORE_LAT + 1;
  localparam int CW = $clog2(TO + 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [ID_W-1:0]        r_ptr;
  logic [CW-1:0]          r_cnt;
  logic [SHA_BLK_W-1:0]   r_msg;
  logic [SHA_DIG_W-1:0]   r_hash;
  logic [ID_W-1:0]        r_id;
  logic                   r_err;

  logic [NUM_REQ-1:0]     w_gnt;
  logic [ID_W-1:0]        w_idx;
  logic                   w_any;
  logic                   w_tmo;

  sha_req_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .any     (w_any)
  );

  assign w_tmo = (r_cnt == CW'(TO));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (|req_valid) w_next = ST_GRANT;
      ST_GRANT: w_next = w_any ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_next = ST_RUN;
      ST_RUN:   if (core_valid || w_tmo) w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_msg   <= '0;
      r_hash  <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_GRANT: begin
          if (w_any) begin
            r_msg <= req_msg[32'(w_idx)*SHA_BLK_W +: SHA_BLK_W];
            r_id  <= w_idx;
            r_ptr <= ID_W'(wrap_inc(
                       {{(32-ID_W){1'b0}}, w_idx},
                       NUM_REQ));
          end
        end
        // Counter reads 1 in the first RUN cycle.
        ST_LOAD: r_cnt <= CW'(1);
        ST_RUN: begin
          if (core_valid) begin
            r_hash <= core_hash;
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_hash <= '0;
            r_err  <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == ST_GRANT) ? w_gnt : '0;
  assign core_clr  = (r_state == ST_RUN);
  assign core_msg  = r_msg;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_hash  = r_hash;
  assign rsp_id    = r_id;
  assign rsp_err   = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha_req_sched.sv
// Bench for sha_req_sched: transaction model + core stand-in.
// Directed vectors with literal digests pin the model.
module tb_sha_req_sched;

  localparam int LAT  = 67;
  localparam int TOUT = 80;

  localparam logic [511:0] ABC_MSG =
    {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_MSG =
    {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic          clk = 1'b0;
  logic          clr;
  logic [3:0]    req_valid;
  logic [2047:0] req_msg;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [255:0]  rsp_hash;
  logic [1:0]    rsp_id;
  logic          rsp_err;
  logic          core_clr;
  logic [511:0]  core_msg;
  logic          core_valid;
  logic [255:0]  core_hash;
  logic          busy;

  always #5 clk = ~clk;

  sha_req_sched dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_msg    (req_msg),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hash   (rsp_hash),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .core_clr   (core_clr),
    .core_msg   (core_msg),
    .core_valid (core_valid),
    .core_hash  (core_hash),
    .busy       (busy)
  );

  function automatic logic [255:0] digest(input logic [511:0] m);
    if (m == ABC_MSG)   return ABC_DIG;
    if (m == EMPTY_MSG) return EMPTY_DIG;
    return m[511:256] ^ m[255:0] ^ {8{32'h0badf00d}};
  endfunction

  function automatic logic [511:0] mk(input int i);
    logic [31:0] w;
    w = 32'ha5c30000 + 32'(i) * 32'h11;
    return {16{w}};
  endfunction

  function automatic logic [3:0] rr_pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 4'(1) << ((p + k) % 4);
    end
    return 4'b0;
  endfunction

  // Core stand-in: valid in the LAT-th cycle with clr released.
  int cc;
  bit stuck;
  always @(posedge clk) begin
    if (core_clr) cc <= cc + 1;
    else          cc <= 0;
  end
  assign core_valid = core_clr && !stuck && (cc == LAT - 1);
  assign core_hash  = digest(core_msg);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model state.
  int           p;
  bit           in_flight;
  int           run_cnt;
  int           n_rsp;
  int           resp_ids[$];
  logic [1:0]   e_id;
  logic [255:0] e_hash;
  logic         e_err;
  logic [511:0] e_msg;
  bit           auto_drop;

  task automatic model_cycle();
    logic [3:0] pick;
    if (clr) begin
      p = 0; in_flight = 0; run_cnt = 0;
      return;
    end
    if (in_flight || req_ready != 4'b0) begin
      pick = in_flight ? 4'b0 : rr_pick(p, req_valid);
      chk("req_ready", 512'(req_ready), 512'(pick));
    end
    if (in_flight) begin
      chk("busy", 512'(busy), 512'(1));
      if (core_clr) begin
        run_cnt++;
        chk("core_msg", core_msg, e_msg);
      end
      if (rsp_valid) begin
        chk("rsp_core_clr", 512'(core_clr), 512'(0));
        chk("rsp_id", 512'(rsp_id), 512'(e_id));
        chk("rsp_hash", 512'(rsp_hash), 512'(e_hash));
        chk("rsp_err", 512'(rsp_err), 512'(e_err));
        if (run_cnt > 0) begin
          chk("run_len", 512'(run_cnt),
              512'(e_err ? TOUT : LAT));
          run_cnt = 0;
        end
        if (rsp_ready) begin
          in_flight = 0;
          n_rsp++;
          resp_ids.push_back(int'(rsp_id));
        end
      end
    end else begin
      chk("idle_core_clr", 512'(core_clr), 512'(0));
      chk("idle_rsp_valid", 512'(rsp_valid), 512'(0));
      for (int k = 0; k < 4; k++) begin
        if (req_ready[k] && req_valid[k]) begin
          in_flight = 1;
          e_id      = 2'(k);
          e_msg     = req_msg[k*512 +: 512];
          e_err     = stuck;
          e_hash    = stuck ? 256'h0 : digest(e_msg);
          p         = (k + 1) % 4;
          run_cnt   = 0;
        end
      end
    end
  endtask

  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    model_cycle();
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~hs;
  endtask

  task automatic wait_valid(input int lim, input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 512'(rsp_valid), 512'(1));
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("acc_drop", 512'(rsp_valid), 512'(0));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy"}, 512'(busy), 512'(0));
    chk({nm, "_core_clr"}, 512'(core_clr), 512'(0));
    chk({nm, "_core_msg"}, core_msg, 512'(0));
    chk({nm, "_req_ready"}, 512'(req_ready), 512'(0));
    chk({nm, "_rsp_valid"}, 512'(rsp_valid), 512'(0));
    chk({nm, "_rsp_hash"}, 512'(rsp_hash), 512'(0));
    chk({nm, "_rsp_id"}, 512'(rsp_id), 512'(0));
    chk({nm, "_rsp_err"}, 512'(rsp_err), 512'(0));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int tgt;
    int n;
    clr = 1'b1; req_valid = 4'hf; req_msg = '0;
    rsp_ready = 1'b0; stuck = 1'b0; auto_drop = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    chk_reset("rst");
    req_valid = 4'h0;
    clr = 1'b0;
    tick();
    tick();

    // All four held high: strict rotation from pointer 0.
    for (int i = 0; i < 4; i++) req_msg[i*512 +: 512] = mk(i);
    auto_drop = 1'b0;
    rsp_ready = 1'b1;
    resp_ids.delete();
    tgt = n_rsp + 5;
    req_valid = 4'hf;
    n = 0;
    while (n_rsp < tgt && n < 500) begin
      tick();
      n++;
    end
    req_valid = 4'h0;
    auto_drop = 1'b1;
    rsp_ready = 1'b0;
    chk("rr_count", 512'(n_rsp >= tgt), 512'(1));
    for (int k = 0; k < 5; k++)
      chk("rr_order", 512'(resp_ids[k]), 512'(exp_order[k]));

    // "abc" on requester 0.
    req_msg[0 +: 512] = ABC_MSG;
    req_valid = 4'b0001;
    wait_valid(200, "t1_wait");
    chk("t1_id", 512'(rsp_id), 512'(0));
    chk("t1_hash", 512'(rsp_hash), 512'(ABC_DIG));
    chk("t1_err", 512'(rsp_err), 512'(0));

    // Consumer stalls 20 cycles with another request pending.
    req_msg[512 +: 512] = mk(1);
    req_valid = 4'b0010;
    repeat (20) tick();
    chk("t4_valid", 512'(rsp_valid), 512'(1));
    chk("t4_id", 512'(rsp_id), 512'(0));
    chk("t4_hash", 512'(rsp_hash), 512'(ABC_DIG));
    chk("t4_ready", 512'(req_ready), 512'(0));
    accept();
    wait_valid(200, "t4b_wait");
    chk("t4b_id", 512'(rsp_id), 512'(1));
    accept();

    // Empty message on requester 2.
    req_msg[1024 +: 512] = EMPTY_MSG;
    req_valid = 4'b0100;
    wait_valid(200, "t2_wait");
    chk("t2_id", 512'(rsp_id), 512'(2));
    chk("t2_hash", 512'(rsp_hash), 512'(EMPTY_DIG));
    chk("t2_err", 512'(rsp_err), 512'(0));
    accept();

    // Core never answers: timeout response.
    stuck = 1'b1;
    req_msg[1536 +: 512] = mk(3);
    req_valid = 4'b1000;
    wait_valid(300, "t5_wait");
    chk("t5_id", 512'(rsp_id), 512'(3));
    chk("t5_err", 512'(rsp_err), 512'(1));
    chk("t5_hash", 512'(rsp_hash), 512'(0));
    accept();
    stuck = 1'b0;

    // Reset at RUN counter 30, then a clean job.
    req_msg[0 +: 512] = ABC_MSG;
    req_valid = 4'b0001;
    n = 0;
    while (!core_clr && n < 20) begin
      tick();
      n++;
    end
    chk("t6_run", 512'(core_clr), 512'(1));
    repeat (29) tick();
    clr = 1'b1;
    tick();
    chk_reset("t6");
    clr = 1'b0;
    repeat (100) tick();
    chk("t6_quiet", 512'(rsp_valid), 512'(0));
    req_valid = 4'b0001;
    wait_valid(200, "t6_wait");
    chk("t6_id", 512'(rsp_id), 512'(0));
    chk("t6_hash", 512'(rsp_hash), 512'(ABC_DIG));
    chk("t6_err", 512'(rsp_err), 512'(0));
    accept();
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
